// File: rtl/apb_regs_hw.sv
// apb_regs_hw: APB4 register bank with RW / RO / W1C registers, hardware
// load and set ports, a programmable wait-state counter and write pulses.

package apb_regs_hw_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;
endpackage

module apb_regs_hw #(
  parameter int                   NoApbRegs    = 4,
  parameter int                   ApbAddrWidth = 32,
  parameter int                   AddrOffset   = 4,
  parameter int                   ApbDataWidth = 32,
  parameter int                   RegDataWidth = 32,
  parameter logic [NoApbRegs-1:0] ReadOnly     = '0,
  parameter logic [NoApbRegs-1:0] W1cMask      = '0,
  parameter int                   WaitCycles   = 0,
  parameter type                  req_t        = apb_regs_hw_pkg::apb_req_t,
  parameter type                  resp_t       = apb_regs_hw_pkg::apb_resp_t
) (
  input  logic                                   pclk_i,
  input  logic                                   preset_ni,
  input  req_t                                   req_i,
  output resp_t                                  resp_o,
  input  logic [ApbAddrWidth-1:0]                base_addr_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_init_i,
  input  logic [NoApbRegs-1:0]                   hw_we_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] hw_d_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] hw_set_i,
  output logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_q_o,
  output logic [NoApbRegs-1:0]                   wr_pulse_o
);
  localparam int StrbWidth = (ApbDataWidth + 7) / 8;
  localparam int AddrExtW  = ApbAddrWidth + 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic                    loaded_reg;
  logic [NoApbRegs-1:0]    wr_pulse_reg;

  logic [ApbAddrWidth-1:0] paddr;
  logic [ApbDataWidth-1:0] pwdata;
  logic [StrbWidth-1:0]    pstrb;
  logic                    psel, penable, pwrite;
  logic                    pready, decode_err, ro_hit, err, wr_ok;
  logic [NoApbRegs-1:0]    hit, wr_hit;
  logic [RegDataWidth-1:0] wmask, wdata, rdata;
  logic                    unused_ok;

  assign paddr     = req_i.paddr;
  assign pwdata    = req_i.pwdata;
  assign pstrb     = req_i.pstrb;
  assign psel      = req_i.psel;
  assign penable   = req_i.penable;
  assign pwrite    = req_i.pwrite;
  assign wdata     = pwdata[RegDataWidth-1:0];
  // Protection bits and per-mode unused hw inputs are deliberately ignored.
  assign unused_ok = ^{req_i.pprot, hw_we_i, hw_d_i, hw_set_i, pwdata};

  genvar gi;

  // Bit k of a register is writable only when its byte lane strobe is set.
  for (gi = 0; gi < RegDataWidth; gi++) begin : g_wmask
    assign wmask[gi] = pstrb[gi/8];
  end

  // Sequential state: FSM, wait counter, post-reset load flag, write pulses
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      loaded_reg   <= 1'b0;
      wr_pulse_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      loaded_reg   <= 1'b1;
      wr_pulse_reg <= wr_hit;
    end
  end

  // Access-phase FSM: count wait states, raise pready on the final cycle
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pready     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (psel && penable) begin
          if (WaitCycles == 0) begin
            pready = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = 4'd1;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          // Master abandoned the transfer: drop it without committing.
          state_next = IDLE;
          count_next = '0;
        end else if (count_reg < 4'(WaitCycles)) begin
          count_next = count_reg + 4'd1;
        end else begin
          pready     = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign decode_err = ~|hit;
  assign ro_hit     = |(hit & ReadOnly);
  assign err        = decode_err | (pwrite & ro_hit);
  // The very first edge after reset is reserved for loading init values.
  assign wr_ok      = pready & pwrite & ~err & (|pstrb) & loaded_reg;
  assign wr_hit     = hit & {NoApbRegs{wr_ok}};
  assign wr_pulse_o = wr_pulse_reg;

  for (gi = 0; gi < NoApbRegs; gi++) begin : g_reg
    localparam logic [AddrExtW-1:0] Offs = AddrExtW'(gi * AddrOffset);
    logic [AddrExtW-1:0] lo;

    // One extra address bit keeps windows near the top of the map from wrapping.
    assign lo      = {1'b0, base_addr_i} + Offs;
    assign hit[gi] = ({1'b0, paddr} >= lo) && ({1'b0, paddr} < lo + AddrExtW'(4));

    if (ReadOnly[gi]) begin : g_ro
      assign reg_q_o[gi] = reg_init_i[gi];
    end else if (W1cMask[gi]) begin : g_w1c
      logic [RegDataWidth-1:0] q_reg, clr;
      assign clr = wr_hit[gi] ? (wdata & wmask) : '0;
      // W1C status: strobed ones clear bits, hardware set wins on the same bit
      always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni)       q_reg <= '0;
        else if (!loaded_reg) q_reg <= reg_init_i[gi];
        else                  q_reg <= (q_reg & ~clr) | hw_set_i[gi];
      end
      assign reg_q_o[gi] = q_reg;
    end else begin : g_rw
      logic [RegDataWidth-1:0] q_reg;
      // RW register: an APB write beats a same-cycle hardware load
      always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni)       q_reg <= '0;
        else if (!loaded_reg) q_reg <= reg_init_i[gi];
        else if (wr_hit[gi])  q_reg <= (q_reg & ~wmask) | (wdata & wmask);
        else if (hw_we_i[gi]) q_reg <= hw_d_i[gi];
      end
      assign reg_q_o[gi] = q_reg;
    end
  end

  // Read mux: windows never overlap, so OR-ing the hit register is exact
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NoApbRegs; i++) begin
      if (hit[i]) rdata = rdata | reg_q_o[i];
    end
  end

  // APB response: read data only on a successful read completion
  always_comb begin
    resp_o         = '0;
    resp_o.pready  = pready;
    resp_o.pslverr = pready & err;
    if (pready && !pwrite && !err) resp_o.prdata = ApbDataWidth'(rdata);
  end

endmodule

// File: tb/tb_apb_regs_hw.sv
// tb_apb_regs_hw: table-driven bench with a response scoreboard for
// apb_regs_hw (A: 3 wait states, stride 4; B: no wait states, stride 8).
module tb_apb_regs_hw;
  import apb_regs_hw_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  apb_req_t  req_a, req_b;
  apb_resp_t resp_a, resp_b;
  logic [31:0]      base;
  logic [3:0][31:0] reg_init, hw_d_a, hw_set_a, reg_q_a, reg_q_b, z4;
  logic [3:0]       hw_we_a, zwe, pulse_a, pulse_b;
  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  pulse;
    int          cycles;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    bit          on_b;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
    logic [3:0]  pulse;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  apb_regs_hw #(
    .NoApbRegs(4), .ApbAddrWidth(32), .AddrOffset(4), .ApbDataWidth(32),
    .RegDataWidth(32), .ReadOnly(4'b0010), .W1cMask(4'b0100), .WaitCycles(3)
  ) u_a (
    .pclk_i(clk), .preset_ni(rst_n), .req_i(req_a), .resp_o(resp_a),
    .base_addr_i(base), .reg_init_i(reg_init), .hw_we_i(hw_we_a),
    .hw_d_i(hw_d_a), .hw_set_i(hw_set_a), .reg_q_o(reg_q_a), .wr_pulse_o(pulse_a)
  );

  apb_regs_hw #(
    .NoApbRegs(4), .ApbAddrWidth(32), .AddrOffset(8), .ApbDataWidth(32),
    .RegDataWidth(32), .ReadOnly(4'b0010), .W1cMask(4'b0100), .WaitCycles(0)
  ) u_b (
    .pclk_i(clk), .preset_ni(rst_n), .req_i(req_b), .resp_o(resp_b),
    .base_addr_i(base), .reg_init_i(reg_init), .hw_we_i(zwe),
    .hw_d_i(z4), .hw_set_i(z4), .reg_q_o(reg_q_b), .wr_pulse_o(pulse_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input bit on_b, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] rdata,
                              input bit err, input logic [3:0] pulse);
    vec_t v;
    v.name = name; v.on_b = on_b; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.strb = strb; v.rdata = rdata; v.err = err; v.pulse = pulse;
    vecs.push_back(v);
  endfunction

  // One APB transfer; hw vectors (DUT A only) are applied in the pready cycle.
  task automatic xfer(input string name, input bit on_b, input bit wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rdata,
                      input bit exp_err, input logic [3:0] exp_pulse,
                      input logic [3:0] we_v, input logic [3:0][31:0] d_v,
                      input logic [3:0][31:0] set_v);
    exp_t e, got;
    apb_req_t r;
    int cyc;
    bit done;
    logic [31:0] rd;
    logic er;
    e.name = name; e.rdata = exp_rdata; e.err = exp_err;
    e.pulse = exp_pulse; e.cycles = on_b ? 1 : 4;
    sb_q.push_back(e);
    r = '0;
    r.paddr = addr; r.pwrite = wr; r.pwdata = wdata; r.pstrb = strb; r.psel = 1'b1;
    @(negedge clk);
    if (on_b) req_b = r; else req_a = r;
    @(negedge clk);
    r.penable = 1'b1;
    if (on_b) req_b = r; else req_a = r;
    cyc = 0;
    done = 0;
    rd = '0;
    er = 1'b0;
    while (!done && cyc < 20) begin
      cyc++;
      #1;
      if ((on_b ? resp_b.pready : resp_a.pready) === 1'b1) done = 1;
      else @(negedge clk);
    end
    got = sb_q.pop_front();
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no pready after %0d cycles, required %0d", got.name, cyc, got.cycles);
    end else begin
      if (!on_b) begin
        hw_we_a = we_v; hw_d_a = d_v; hw_set_a = set_v;
      end
      rd = on_b ? resp_b.prdata : resp_a.prdata;
      er = on_b ? resp_b.pslverr : resp_a.pslverr;
      check({got.name, " prdata"}, rd, got.rdata);
      check({got.name, " pslverr"}, {31'b0, er}, {31'b0, got.err});
      check({got.name, " latency"}, 32'(cyc), 32'(got.cycles));
    end
    @(negedge clk);
    req_a = '0; req_b = '0;
    hw_we_a = '0; hw_d_a = '0; hw_set_a = '0;
    check({got.name, " wr_pulse"}, {28'b0, on_b ? pulse_b : pulse_a}, {28'b0, got.pulse});
    @(negedge clk);
    check({got.name, " wr_pulse drop"}, {28'b0, on_b ? pulse_b : pulse_a}, 32'b0);
    $display("[TB] %s: %s addr=0x%08h prdata=0x%08h pslverr=%0b cycles=%0d",
             got.name, wr ? "WR" : "RD", addr, rd, er, cyc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][31:0] sv, dv;
    apb_req_t r;
    rst_n = 1'b0;
    req_a = '0; req_b = '0;
    base = 32'h1000;
    hw_we_a = '0; hw_d_a = '0; hw_set_a = '0;
    z4 = '0; zwe = '0;
    reg_init[0] = 32'h0000_0000;
    reg_init[1] = 32'hA5A5_0001;
    reg_init[2] = 32'h0000_00F0;
    reg_init[3] = 32'h3333_3333;

    // Reset state and the post-release load edge
    repeat (3) @(negedge clk);
    check("rst reg_q[3]", reg_q_a[3], 32'h0);
    check("rst reg_q[2]", reg_q_a[2], 32'h0);
    check("rst wr_pulse", {28'b0, pulse_a}, 32'h0);
    check("rst pready", {31'b0, resp_a.pready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("load reg_q[3]", reg_q_a[3], 32'h3333_3333);
    check("load reg_q[2]", reg_q_a[2], 32'h0000_00F0);
    check("ro passthrough", reg_q_a[1], 32'hA5A5_0001);
    check("load b reg_q[2]", reg_q_b[2], 32'h0000_00F0);
    @(negedge clk);

    //  name              B  wr addr          wdata         strb     rdata         err pulse
    add("a rd ro init",   0, 0, 32'h1004, 32'h0,         4'hF,    32'hA5A5_0001, 0, 4'b0000);
    add("a rd w1c init",  0, 0, 32'h1008, 32'h0,         4'hF,    32'h0000_00F0, 0, 4'b0000);
    add("a rd past end",  0, 0, 32'h1010, 32'h0,         4'hF,    32'h0,         1, 4'b0000);
    add("a wr ro",        0, 1, 32'h1004, 32'hFFFF_FFFF, 4'hF,    32'h0,         1, 4'b0000);
    add("a rd ro after",  0, 0, 32'h1004, 32'h0,         4'hF,    32'hA5A5_0001, 0, 4'b0000);
    add("a rd below",     0, 0, 32'h0FFC, 32'h0,         4'hF,    32'h0,         1, 4'b0000);
    add("a rd mid word",  0, 0, 32'h100E, 32'h0,         4'hF,    32'h3333_3333, 0, 4'b0000);
    add("a wr strb0",     0, 1, 32'h100C, 32'h0,         4'h0,    32'h0,         0, 4'b0000);
    add("a rd strb0",     0, 0, 32'h100C, 32'h0,         4'hF,    32'h3333_3333, 0, 4'b0000);
    add("a wr beef",      0, 1, 32'h1000, 32'hDEAD_BEEF, 4'b0011, 32'h0,         0, 4'b0001);
    add("a rd beef",      0, 0, 32'h1000, 32'h0,         4'hF,    32'h0000_BEEF, 0, 4'b0000);
    add("b rd gap",       1, 0, 32'h1004, 32'h0,         4'hF,    32'h0,         1, 4'b0000);
    add("b wr gap",       1, 1, 32'h1004, 32'h1234_5678, 4'hF,    32'h0,         1, 4'b0000);
    add("b rd ro",        1, 0, 32'h1008, 32'h0,         4'hF,    32'hA5A5_0001, 0, 4'b0000);
    add("b rd reg3",      1, 0, 32'h1018, 32'h0,         4'hF,    32'h3333_3333, 0, 4'b0000);
    add("b rd past end",  1, 0, 32'h1020, 32'h0,         4'hF,    32'h0,         1, 4'b0000);
    add("b w1c clear",    1, 1, 32'h1010, 32'h0000_00F0, 4'hF,    32'h0,         0, 4'b0100);
    add("b rd w1c",       1, 0, 32'h1010, 32'h0,         4'hF,    32'h0,         0, 4'b0000);
    add("b wr strb0101",  1, 1, 32'h1018, 32'h1234_5678, 4'b0101, 32'h0,         0, 4'b1000);
    add("b rd strb0101",  1, 0, 32'h1018, 32'h0,         4'hF,    32'h3334_3378, 0, 4'b0000);

    foreach (vecs[i]) begin
      xfer(vecs[i].name, vecs[i].on_b, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].strb, vecs[i].rdata, vecs[i].err, vecs[i].pulse, 4'b0, z4, z4);
    end

    // W1C clear and hardware set in the same cycle: set wins on bit 4
    sv = '0;
    sv[2] = 32'h10;
    xfer("a w1c set wins", 0, 1, 32'h1008, 32'h30, 4'hF, 32'h0, 0, 4'b0100, 4'b0, z4, sv);
    xfer("a rd w1c", 0, 0, 32'h1008, 32'h0, 4'hF, 32'h0000_00D0, 0, 4'b0000, 4'b0, z4, z4);

    // RW: APB write beats a same-cycle hw load, then a lone hw load lands
    dv = '0;
    dv[3] = 32'h55;
    xfer("a rw apb wins", 0, 1, 32'h100C, 32'h77, 4'hF, 32'h0, 0, 4'b1000, 4'b1000, dv, z4);
    check("rw after apb", reg_q_a[3], 32'h77);
    @(negedge clk);
    hw_we_a = 4'b1000;
    hw_d_a = dv;
    @(negedge clk);
    hw_we_a = '0;
    hw_d_a = '0;
    check("rw hw load", reg_q_a[3], 32'h55);
    xfer("a rd hw load", 0, 0, 32'h100C, 32'h0, 4'hF, 32'h55, 0, 4'b0000, 4'b0, z4, z4);

    // hw_we is ignored by a W1C register
    @(negedge clk);
    hw_we_a = 4'b0100;
    hw_d_a[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    hw_we_a = '0;
    hw_d_a = '0;
    check("w1c ignores hw_we", reg_q_a[2], 32'h0000_00D0);

    // Asynchronous reset at wait count 2 aborts the write
    r = '0;
    r.paddr = 32'h1000; r.pwrite = 1'b1; r.pwdata = 32'hCAFE_F00D; r.pstrb = 4'hF; r.psel = 1'b1;
    @(negedge clk);
    req_a = r;
    @(negedge clk);
    r.penable = 1'b1;
    req_a = r;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("wait cnt2 pready", {31'b0, resp_a.pready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort pready", {31'b0, resp_a.pready}, 32'h0);
    check("async clear reg3", reg_q_a[3], 32'h0);
    @(negedge clk);
    req_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort reg0 init", reg_q_a[0], 32'h0);
    check("abort reg3 init", reg_q_a[3], 32'h3333_3333);
    check("abort no pulse", {28'b0, pulse_a}, 32'h0);
    $display("[TB] reset abort: reg0=0x%08h reg3=0x%08h", reg_q_a[0], reg_q_a[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
